rc4_decrypt_check: RTL and testbench
====================================

# rc4_decrypt_check

Per-core RC4 keystream generation and plaintext validation stage. It is started after the core's key-scheduling pass has filled the S RAM. It runs the PRGA over the encrypted message ROM and writes each decrypted byte to the core's result RAM. Each byte is checked against the plaintext alphabet. The outcome goes to the multi-core key controller: `update_request` on a bad byte (request next key), `done` on a full valid message.

## Interface
Parameters:
- `MSG_LEN`, 32: message length in bytes; range 1..256.
- `MSG_AW`, 5: message address width; must satisfy 2^MSG_AW ≥ MSG_LEN.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `start`  in  1  one-cycle pulse; sampled only in IDLE.
- `key_ack`  in  1  controller's start-next-key pulse for this core; clears a pending `update_request`.
- `s_addr`  out  8  S RAM address.
- `s_wdata`  out  8  S RAM write data.
- `s_wren`  out  1  S RAM write enable.
- `s_rdata`  in  8  S RAM read data.
- `rom_addr`  out  MSG_AW  encrypted-message ROM address.
- `rom_rdata`  in  8  ROM read data.
- `dec_addr`  out  MSG_AW  decrypted RAM address.
- `dec_wdata`  out  8  decrypted RAM write data.
- `dec_wren`  out  1  decrypted RAM write enable.
- `busy`  out  1  high in every state except IDLE, FAIL and PASS.
- `update_request`  out  1  level; high in FAIL.
- `done`  out  1  level; high in PASS (the controller's end_3 input).

## Operation
- Registers `i`, `j`, `si`, `sj` are 8-bit; message index `k` is MSG_AW-bit.
- All S arithmetic is mod 256 (natural 8-bit wrap).
- States, in per-byte order: IDLE, INC_I, RD_SI, WAIT_SI, CAP_SI, RD_SJ, WAIT_SJ, CAP_SJ, WR_SI, WR_SJ, RD_F, WAIT_F, WR_DEC, plus terminal FAIL and PASS.
- IDLE: on `start`, clear `i`, `j` and `k`, then go to INC_I.
- INC_I: `i <= i+1`.
- RD_SI: drive `s_addr=i`.
- WAIT_SI: wait one cycle.
- CAP_SI: `si <= s_rdata`; `j <= j + s_rdata`.
- RD_SJ: drive `s_addr=j`.
- WAIT_SJ: wait one cycle.
- CAP_SJ: `sj <= s_rdata`.
- WR_SI: write `s[i] = sj`.
- WR_SJ: write `s[j] = si`.
- RD_F: drive `s_addr = si+sj` and `rom_addr = k`.
- WAIT_F: wait one cycle.
- WR_DEC: write `dec[k] = s_rdata ^ rom_rdata`, and evaluate the same value:
  - A byte is valid iff it is 0x20 or in 0x61..0x7A.
  - Invalid byte: go to FAIL.
  - Valid byte with `k == MSG_LEN-1`: go to PASS.
  - Otherwise: `k <= k+1`, go to INC_I.
- The failing byte is still written to the decrypted RAM. No further writes happen after it.
- FAIL: hold `update_request=1` until `key_ack`, then go to IDLE. `start` is ignored in FAIL.
- PASS: sticky; `done=1` until `reset`. `start` and `key_ack` are ignored.
- `start` while `busy` is ignored.
- `key_ack` outside FAIL has no effect.
- Outputs are decoded from the current state and registers, with no extra register stage. Address outputs are 0 in states that do not drive them. Write enables are high only in WR_SI, WR_SJ and WR_DEC.

## Timing
- Reset values: state IDLE; `i=j=k=si=sj=0`; all outputs 0.
- Reset mid-operation: IDLE on the next edge and all outputs 0. An S RAM swap may be left half-done; the upstream stage re-runs KSA before the next `start`.
- RAM/ROM reads: data is sampled 2 cycles after the address is driven. This tolerates a registered-address M10K.
- Per byte: exactly 12 cycles, INC_I through WR_DEC.
- `start` is sampled at edge 0. Byte k is in WR_DEC in cycle 12k+12.
- Full pass: PASS, and `done`, in cycle 12·MSG_LEN+1. This is 385 for MSG_LEN=32.
- Failure at byte k: `update_request` rises in cycle 12k+13.
- `key_ack` sampled at edge t: `update_request` is low from cycle t+1.
- `key_ack` and `reset` in the same cycle: reset wins.

## Structure
- Package `rc4_pkg`: state enum `dc_state_t`, plus constants `CHAR_SPACE=8'h20`, `CHAR_LO=8'h61`, `CHAR_HI=8'h7A`, `S_AW=8`.
- Sub-module `rc4_char_check`: combinational 8-bit validity test. It is reused by the controller-side debug logic.
- Top: single FSM `always_ff`, datapath registers, and output decode.

## Test plan
- Pass case: S model preloaded as identity (`s[x]=x`); ROM = Python-model keystream XOR "attack at dawn" padded with spaces to 32 bytes. Required: `dec[0..31]` match; `done=1` at cycle 385; `update_request` never high.
- Fail at byte 0: identity S gives first keystream byte 0x02; `rom[0]=0x02`. Required: `dec[0]=0x00`, `update_request=1` at cycle 13, no further `dec_wren`; `key_ack` at cycle 60 gives `update_request=0` at cycle 61, `busy=0`, state IDLE.
- Alphabet boundaries via `rom[0]`: plaintexts 0x20, 0x61 and 0x7A continue to byte 1; 0x1F, 0x60 and 0x7B fail.
- Reset at cycle 130 (byte 10): all outputs 0 from cycle 131. A subsequent `start` restarts at `i=j=k=0`; the first `dec_wren` has `dec_addr=0`.
- `start` pulsed at cycles 5 and 200 of a running pass: ignored; done timing unchanged. `start` during FAIL: ignored, `update_request` stays high. `key_ack` during PASS: `done` stays 1.
- `MSG_LEN=1`: a valid byte gives `done` at cycle 13.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 keystream/decrypt-check stage.
package rc4_pkg;

    localparam int unsigned S_AW = 8;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;

    typedef enum logic [3:0] {
        IDLE,
        INC_I,
        RD_SI,
        WAIT_SI,
        CAP_SI,
        RD_SJ,
        WAIT_SJ,
        CAP_SJ,
        WR_SI,
        WR_SJ,
        RD_F,
        WAIT_F,
        WR_DEC,
        FAIL,
        PASS
    } dc_state_t;

endpackage

// File: rtl/rc4_char_check.sv
// Combinational plaintext alphabet test: space or lowercase a..z.
module rc4_char_check
    import rc4_pkg::*;
(
    input  logic [7:0] ch,
    output logic       valid_c
);

    assign valid_c = (ch == CHAR_SPACE) || ((ch >= CHAR_LO) && (ch <= CHAR_HI));

endmodule

// File: rtl/rc4_decrypt_check.sv
// RC4 PRGA over the encrypted message ROM; writes plaintext and flags the
// first out-of-alphabet byte (update_request) or a fully valid message (done).
module rc4_decrypt_check #(
    parameter int unsigned MSG_LEN = 32,
    parameter int unsigned MSG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              key_ack,
    output logic [7:0]        s_addr,
    output logic [7:0]        s_wdata,
    output logic              s_wren,
    input  logic [7:0]        s_rdata,
    output logic [MSG_AW-1:0] rom_addr,
    input  logic [7:0]        rom_rdata,
    output logic [MSG_AW-1:0] dec_addr,
    output logic [7:0]        dec_wdata,
    output logic              dec_wren,
    output logic              busy,
    output logic              update_request,
    output logic              done
);
    import rc4_pkg::*;

    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    dc_state_t         state, state_n;
    logic [S_AW-1:0]   i, j, si, sj;
    logic [MSG_AW-1:0] k;
    logic [7:0]        dec_byte;
    logic              byte_ok_c;

    assign dec_byte = s_rdata ^ rom_rdata;

    rc4_char_check u_char_check (
        .ch      (dec_byte),
        .valid_c (byte_ok_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath registers; reads are captured two cycles after their address state.
    always_ff @(posedge clk) begin
        if (reset) begin
            i  <= '0;
            j  <= '0;
            si <= '0;
            sj <= '0;
            k  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        i <= '0;
                        j <= '0;
                        k <= '0;
                    end
                end
                INC_I:  i <= i + 8'd1;
                CAP_SI: begin
                    si <= s_rdata;
                    j  <= j + s_rdata;
                end
                CAP_SJ: sj <= s_rdata;
                WR_DEC: begin
                    if (byte_ok_c && (k != K_LAST)) begin
                        k <= k + MSG_AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n        = state;
        s_addr         = '0;
        s_wdata        = '0;
        s_wren         = 1'b0;
        rom_addr       = '0;
        dec_addr       = '0;
        dec_wdata      = '0;
        dec_wren       = 1'b0;
        busy           = 1'b1;
        update_request = 1'b0;
        done           = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_n = INC_I;
            end
            INC_I:   state_n = RD_SI;
            RD_SI: begin
                s_addr  = i;
                state_n = WAIT_SI;
            end
            WAIT_SI: state_n = CAP_SI;
            CAP_SI:  state_n = RD_SJ;
            RD_SJ: begin
                s_addr  = j;
                state_n = WAIT_SJ;
            end
            WAIT_SJ: state_n = CAP_SJ;
            CAP_SJ:  state_n = WR_SI;
            WR_SI: begin
                s_addr  = i;
                s_wdata = sj;
                s_wren  = 1'b1;
                state_n = WR_SJ;
            end
            WR_SJ: begin
                s_addr  = j;
                s_wdata = si;
                s_wren  = 1'b1;
                state_n = RD_F;
            end
            RD_F: begin
                s_addr   = si + sj;
                rom_addr = k;
                state_n  = WAIT_F;
            end
            WAIT_F:  state_n = WR_DEC;
            // The failing byte is still written so the controller can inspect it.
            WR_DEC: begin
                dec_addr  = k;
                dec_wdata = dec_byte;
                dec_wren  = 1'b1;
                if (!byte_ok_c) begin
                    state_n = FAIL;
                end else if (k == K_LAST) begin
                    state_n = PASS;
                end else begin
                    state_n = INC_I;
                end
            end
            FAIL: begin
                busy           = 1'b0;
                update_request = 1'b1;
                if (key_ack) state_n = IDLE;
            end
            PASS: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rc4_decrypt_check.sv
// Randomized bench for rc4_decrypt_check against a behavioural RC4 PRGA model,
// with a 2-cycle-latency S RAM and ROM model shared by a 32-byte and a 1-byte instance.
module tb_rc4_decrypt_check;

    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    bit reset, go, sel, key_ack, load_req;
    logic start0, start1;
    assign start0 = go & ~sel;
    assign start1 = go & sel;

    logic [7:0]    s_addr0, s_wdata0, dec_wdata0, s_addr1, s_wdata1, dec_wdata1;
    logic [AW-1:0] rom_addr0, dec_addr0, rom_addr1, dec_addr1;
    logic          s_wren0, dec_wren0, busy0, upd0, done0;
    logic          s_wren1, dec_wren1, busy1, upd1, done1;
    logic [7:0]    s_rdata, rom_rdata;

    rc4_decrypt_check #(.MSG_LEN(32), .MSG_AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start0), .key_ack(key_ack),
        .s_addr(s_addr0), .s_wdata(s_wdata0), .s_wren(s_wren0), .s_rdata(s_rdata),
        .rom_addr(rom_addr0), .rom_rdata(rom_rdata),
        .dec_addr(dec_addr0), .dec_wdata(dec_wdata0), .dec_wren(dec_wren0),
        .busy(busy0), .update_request(upd0), .done(done0)
    );

    rc4_decrypt_check #(.MSG_LEN(1), .MSG_AW(AW)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .key_ack(key_ack),
        .s_addr(s_addr1), .s_wdata(s_wdata1), .s_wren(s_wren1), .s_rdata(s_rdata),
        .rom_addr(rom_addr1), .rom_rdata(rom_rdata),
        .dec_addr(dec_addr1), .dec_wdata(dec_wdata1), .dec_wren(dec_wren1),
        .busy(busy1), .update_request(upd1), .done(done1)
    );

    // Idle instance drives zeros, so the memory buses can simply be OR-merged.
    logic [7:0]    s_addr_m, s_wdata_m, dec_wdata_m;
    logic [AW-1:0] rom_addr_m, dec_addr_m;
    logic          s_wren_m, dec_wren_m, busy_m, upd_m, done_m, any_out;
    assign s_addr_m    = s_addr0 | s_addr1;
    assign s_wdata_m   = s_wdata0 | s_wdata1;
    assign s_wren_m    = s_wren0 | s_wren1;
    assign rom_addr_m  = rom_addr0 | rom_addr1;
    assign dec_addr_m  = dec_addr0 | dec_addr1;
    assign dec_wdata_m = dec_wdata0 | dec_wdata1;
    assign dec_wren_m  = dec_wren0 | dec_wren1;
    assign busy_m      = sel ? busy1 : busy0;
    assign upd_m       = sel ? upd1 : upd0;
    assign done_m      = sel ? done1 : done0;
    assign any_out     = |{s_addr_m, s_wdata_m, s_wren_m, rom_addr_m, dec_addr_m,
                           dec_wdata_m, dec_wren_m, busy_m, upd_m, done_m};

    // Memories: registered address plus registered data (2-cycle read latency).
    logic [7:0]    s_mem [256];
    logic [7:0]    s_init [256];
    logic [7:0]    rom_img [32];
    logic [7:0]    s_aq;
    logic [AW-1:0] rom_aq;
    always @(posedge clk) begin
        s_aq      <= s_addr_m;
        s_rdata   <= s_mem[s_aq];
        rom_aq    <= rom_addr_m;
        rom_rdata <= rom_img[rom_aq];
        if (load_req) begin
            for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
        end else if (s_wren_m) begin
            s_mem[s_addr_m] <= s_wdata_m;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference model: RC4 PRGA on an array copy of the initial S.
    logic [7:0] ks [256];
    function automatic void ref_ks(input int n);
        logic [7:0] s [256];
        logic [7:0] i, j, t;
        for (int x = 0; x < 256; x++) s[x] = s_init[x];
        i = 8'd0;
        j = 8'd0;
        for (int q = 0; q < n; q++) begin
            i    = i + 8'd1;
            j    = j + s[i];
            t    = s[i];
            s[i] = s[j];
            s[j] = t;
            t    = s[i] + s[j];
            ks[q] = s[t];
        end
    endfunction

    function automatic bit char_ok(input logic [7:0] c);
        return (c == 8'h20) || (c >= 8'h61 && c <= 8'h7a);
    endfunction

    function automatic int first_bad(input int n);
        for (int q = 0; q < n; q++) begin
            if (!char_ok(ks[q] ^ rom_img[q])) return q;
        end
        return -1;
    endfunction

    string pt_str = "attack at dawn";
    function automatic logic [7:0] pt_byte(input int q);
        return (q < pt_str.len()) ? 8'(pt_str[q]) : 8'h20;
    endfunction

    function automatic logic [7:0] rand_valid();
        int r = $urandom_range(0, 26);
        return (r == 26) ? 8'h20 : 8'h61 + 8'(r);
    endfunction

    int wr_addr_q [$];
    int wr_data_q [$];
    int wr_cyc_q  [$];
    int done_cyc, upd_cyc, upd_fall, post_rst_bad;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Cycle n is the cycle following edge n-1, where edge 0 samples start.
    task automatic run_job(input bit use1, input int st_a, input int st_b,
                           input int ack_at, input int rst_at, input int stop_at);
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_cyc = -1; upd_cyc = -1; upd_fall = -1; post_rst_bad = 0;
        sel      = use1;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int n = 1; n <= stop_at; n++) begin
            if (dec_wren_m) begin
                wr_addr_q.push_back(int'(dec_addr_m));
                wr_data_q.push_back(int'(dec_wdata_m));
                wr_cyc_q.push_back(n);
            end
            if (upd_m) begin
                if (upd_cyc < 0) upd_cyc = n;
            end else if (upd_cyc >= 0 && upd_fall < 0) begin
                upd_fall = n;
            end
            if (done_m && done_cyc < 0) done_cyc = n;
            if (rst_at > 0 && n > rst_at && any_out) post_rst_bad++;
            go      = (n == st_a) || (n == st_b);
            key_ack = (n == ack_at);
            reset   = (n == rst_at);
            tick();
        end
        go = 1'b0; key_ack = 1'b0; reset = 1'b0;
    endtask

    task automatic verify_job(input string tag, input int n);
        int fb, exp_w;
        fb    = first_bad(n);
        exp_w = (fb < 0) ? n : fb + 1;
        check({tag, "_wr_count"}, wr_addr_q.size(), exp_w);
        for (int w = 0; w < wr_addr_q.size() && w < exp_w; w++) begin
            check({tag, "_wr_addr"}, wr_addr_q[w], w);
            check({tag, "_wr_data"}, wr_data_q[w], int'(ks[w] ^ rom_img[w]));
            check({tag, "_wr_cyc"},  wr_cyc_q[w], 12 * w + 12);
        end
        check({tag, "_done_cyc"}, done_cyc, (fb < 0) ? 12 * n + 1 : -1);
        check({tag, "_upd_cyc"},  upd_cyc,  (fb < 0) ? -1 : 12 * fb + 13);
    endtask

    task automatic load_identity();
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    endtask

    logic [7:0] bnd_pt [6] = '{8'h20, 8'h61, 8'h7a, 8'h1f, 8'h60, 8'h7b};

    initial begin
        reset = 1'b0; go = 1'b0; sel = 1'b0; key_ack = 1'b0; load_req = 1'b0;
        for (int q = 0; q < 32; q++) rom_img[q] = 8'h00;
        load_identity();
        tick();
        do_reset();

        check("rst_busy", busy0, 0);
        check("rst_upd", upd0, 0);
        check("rst_done", done0, 0);
        check("rst_s_wren", s_wren0, 0);
        check("rst_dec_wren", dec_wren0, 0);
        check("rst_s_addr", s_addr0, 0);
        check("rst_rom_addr", rom_addr0, 0);

        // Full valid pass with stray start pulses and a key_ack while in PASS.
        load_identity();
        ref_ks(32);
        for (int q = 0; q < 32; q++) rom_img[q] = ks[q] ^ pt_byte(q);
        run_job(1'b0, 5, 200, 390, 0, 400);
        verify_job("pass", 32);
        check("pass_done_385", done_cyc, 385);
        check("pass_done_held", done_m, 1);
        check("pass_upd_never", upd_cyc, -1);
        do_reset();

        // Fail at byte 0; start during FAIL is ignored, key_ack at 60 returns to IDLE.
        load_identity();
        ref_ks(32);
        for (int q = 0; q < 32; q++) rom_img[q] = 8'($urandom);
        rom_img[0] = 8'h02;
        run_job(1'b0, 30, 0, 60, 0, 70);
        verify_job("f0", 32);
        check("f0_ks0", ks[0], 8'h02);
        check("f0_upd_13", upd_cyc, 13);
        check("f0_upd_fall_61", upd_fall, 61);
        check("f0_busy_idle", busy_m, 0);
        check("f0_upd_idle", upd_m, 0);
        check("f0_done_idle", done_m, 0);

        // Alphabet boundaries on byte 0; byte 1 is forced invalid to end each job.
        foreach (bnd_pt[b]) begin
            load_identity();
            ref_ks(32);
            rom_img[0] = ks[0] ^ bnd_pt[b];
            rom_img[1] = ks[1];
            run_job(1'b0, 0, 0, 40, 0, 45);
            verify_job("bnd", 32);
            check("bnd_upd_cyc", upd_cyc, (b < 3) ? 25 : 13);
            do_reset();
        end

        // Reset during byte 10, then a clean restart from i=j=k=0.
        load_identity();
        ref_ks(32);
        for (int q = 0; q < 32; q++) rom_img[q] = ks[q] ^ pt_byte(q);
        run_job(1'b0, 0, 0, 0, 130, 140);
        check("rst130_writes", wr_addr_q.size(), 10);
        check("rst130_outputs_zero", post_rst_bad, 0);
        check("rst130_no_done", done_cyc, -1);
        run_job(1'b0, 0, 0, 0, 0, 390);
        verify_job("restart", 32);
        do_reset();

        // Random S permutations and plaintexts, some with one bad byte.
        for (int it = 0; it < 6; it++) begin
            logic [7:0] t;
            int bad_at;
            load_identity();
            for (int x = 255; x > 0; x--) begin
                int y = $urandom_range(0, x);
                t = s_init[x]; s_init[x] = s_init[y]; s_init[y] = t;
            end
            ref_ks(32);
            bad_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 31) : -1;
            for (int q = 0; q < 32; q++) begin
                t = rand_valid();
                if (q == bad_at) begin
                    do t = 8'($urandom); while (char_ok(t));
                end
                rom_img[q] = ks[q] ^ t;
            end
            run_job(1'b0, 0, 0, 0, 0, 12 * 32 + 10);
            verify_job("rand", 32);
            check("rand_bad_idx", first_bad(32), bad_at);
            do_reset();
        end

        // Single-byte message instance.
        load_identity();
        ref_ks(1);
        rom_img[0] = ks[0] ^ 8'h61;
        run_job(1'b1, 0, 0, 0, 0, 20);
        verify_job("len1", 1);
        check("len1_done_13", done_cyc, 13);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
